// File: rtl/vp_pkg.sv
// Shared definitions for the vector-processor issue sequencer:
// instruction field positions, last-issued class encoding and decode helpers.
package vp_pkg;

    localparam int OP_ALU_BIT = 12;
    localparam int OP_ST_BIT  = 11;
    localparam int REG_MSB    = 10;
    localparam int REG_LSB    = 9;
    localparam int ADDR_W     = 9;
    localparam int INSTR_W    = 13;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_LOAD01 = 3'd1,
        CLS_LOAD23 = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_ALU    = 3'd4
    } instr_class_t;

    // Classify an instruction for hazard tracking.
    function automatic instr_class_t instr_class(input logic [INSTR_W-1:0] instr);
        instr_class_t cls;
        if (instr[OP_ALU_BIT])
            cls = CLS_ALU;
        else if (instr[OP_ST_BIT])
            cls = CLS_STORE;
        else if (instr[REG_MSB])
            cls = CLS_LOAD23;
        else
            cls = CLS_LOAD01;
        return cls;
    endfunction

    // ALU reading R0/R1 right after a load into R0/R1, or a store of R2/R3
    // right after an ALU op that writes R2/R3.
    function automatic logic is_hazard(input logic [INSTR_W-1:0] head,
                                       input instr_class_t       last);
        logic alu_after_load;
        logic store_after_alu;
        alu_after_load  = head[OP_ALU_BIT] && (last == CLS_LOAD01);
        store_after_alu = !head[OP_ALU_BIT] && head[OP_ST_BIT] && head[REG_MSB]
                          && (last == CLS_ALU);
        return alu_after_load || store_after_alu;
    endfunction

endpackage

// File: rtl/vp_instr_fifo.sv
// Instruction FIFO with first-word-fall-through head, occupancy count and flush.
module vp_instr_fifo
    import vp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [INSTR_W-1:0]       i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [INSTR_W-1:0]       o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_C = DEPTH[PTR_W:0];

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push & ~i_flush & (r_count != FULL_C);
    assign w_do_pop  = i_pop  & ~i_flush & (r_count != '0);

    // Storage array; contents are only meaningful below r_count, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally at the power-of-two depth; flush empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/vp_issue_sequencer.sv
// Issues queued vector instructions one at a time, holding each on instruct
// for HOLD_CYCLES and inserting STALL_CYCLES before load->ALU / ALU->store hazards.
module vp_issue_sequencer
    import vp_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int HOLD_CYCLES  = 2,
    parameter int STALL_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [INSTR_W-1:0]       instruct,
    output logic                     issue_pulse,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issued_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CMAX  = (HOLD_CYCLES > STALL_CYCLES) ? HOLD_CYCLES : STALL_CYCLES;
    localparam int TMR_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STALL_LD = TMR_W'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    instr_class_t       r_last_class;
    logic [INSTR_W-1:0] r_instruct;
    logic               r_issue_pulse;
    logic [15:0]        r_issued_count;

    logic [INSTR_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic               w_push;
    logic               w_timer_zero;
    logic               w_eval;
    logic               w_hazard;
    logic               w_issue;
    logic               w_stall;

    assign in_ready     = (w_count < DEPTH_C) & ~flush;
    assign w_push       = in_valid & in_ready;
    assign w_timer_zero = (r_timer == '0);
    // A new head is examined from IDLE or on the last cycle of a hold.
    assign w_eval       = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & w_timer_zero);
    assign w_hazard     = is_hazard(w_head, r_last_class);
    assign w_issue      = ~flush & ((w_eval & ~w_empty & ~w_hazard)
                                    | ((r_state == ST_STALL) & w_timer_zero));
    assign w_stall      = ~flush & w_eval & ~w_empty & w_hazard;

    vp_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (in_instr),
        .i_pop   (w_issue),
        .i_flush (flush),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Issue FSM with registered instruct, strobe, issue counter and hazard history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_timer        <= '0;
            r_last_class   <= CLS_NONE;
            r_instruct     <= '0;
            r_issue_pulse  <= 1'b0;
            r_issued_count <= '0;
        end else begin
            r_issue_pulse <= w_issue;
            if (flush) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
            end else if (w_issue) begin
                r_instruct     <= w_head;
                r_issued_count <= r_issued_count + 16'd1;
                r_last_class   <= instr_class(w_head);
                r_state        <= ST_HOLD;
                r_timer        <= HOLD_LD;
            end else if (w_stall) begin
                r_state <= ST_STALL;
                r_timer <= STALL_LD;
            end else if ((r_state != ST_IDLE) && !w_timer_zero) begin
                r_timer <= r_timer - 1'b1;
            end else if (r_state == ST_HOLD) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign instruct     = r_instruct;
    assign issue_pulse  = r_issue_pulse;
    assign issued_count = r_issued_count;
    assign fifo_count   = w_count;
    assign busy         = ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_vp_issue_sequencer.sv
// Directed bench for vp_issue_sequencer: a default instance, a long-hold
// instance for FIFO fill/flush, and a single-cycle-hold instance for counter wrap.
module tb_vp_issue_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // default instance (HOLD 2, STALL 1)
    logic [12:0] m_in_instr;
    logic        m_in_valid, m_flush, m_in_ready, m_pulse, m_busy;
    logic [12:0] m_instruct;
    logic [3:0]  m_count;
    logic [15:0] m_issued;

    // long-hold instance
    logic [12:0] l_in_instr;
    logic        l_in_valid, l_flush, l_in_ready, l_pulse, l_busy;
    logic [12:0] l_instruct;
    logic [3:0]  l_count;
    logic [15:0] l_issued;

    // single-cycle-hold instance
    logic [12:0] wr_in_instr;
    logic        wr_in_valid, wr_flush, wr_in_ready, wr_pulse, wr_busy;
    logic [12:0] wr_instruct;
    logic [3:0]  wr_count;
    logic [15:0] wr_issued;

    vp_issue_sequencer #(.DEPTH(8), .HOLD_CYCLES(2), .STALL_CYCLES(1)) u_main (
        .clk(clk), .reset(reset), .in_instr(m_in_instr), .in_valid(m_in_valid),
        .in_ready(m_in_ready), .flush(m_flush), .instruct(m_instruct),
        .issue_pulse(m_pulse), .busy(m_busy), .fifo_count(m_count),
        .issued_count(m_issued)
    );

    vp_issue_sequencer #(.DEPTH(8), .HOLD_CYCLES(64), .STALL_CYCLES(1)) u_long (
        .clk(clk), .reset(reset), .in_instr(l_in_instr), .in_valid(l_in_valid),
        .in_ready(l_in_ready), .flush(l_flush), .instruct(l_instruct),
        .issue_pulse(l_pulse), .busy(l_busy), .fifo_count(l_count),
        .issued_count(l_issued)
    );

    vp_issue_sequencer #(.DEPTH(8), .HOLD_CYCLES(1), .STALL_CYCLES(1)) u_wrap (
        .clk(clk), .reset(reset), .in_instr(wr_in_instr), .in_valid(wr_in_valid),
        .in_ready(wr_in_ready), .flush(wr_flush), .instruct(wr_instruct),
        .issue_pulse(wr_pulse), .busy(wr_busy), .fifo_count(wr_count),
        .issued_count(wr_issued)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_m(input logic [12:0] w);
        m_in_instr = w;
        m_in_valid = 1'b1;
        @(negedge clk);
        m_in_valid = 1'b0;
    endtask

    task automatic push_l(input logic [12:0] w);
        l_in_instr = w;
        l_in_valid = 1'b1;
        @(negedge clk);
        l_in_valid = 1'b0;
    endtask

    // Cycles until the next issue_pulse on the default instance; 0 on timeout.
    task automatic wait_pulse_m(output int n);
        n = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (m_pulse) begin
                n = t;
                break;
            end
        end
    endtask

    task automatic wait_idle_m(input string tag);
        for (int t = 0; t < 50 && m_busy; t++)
            @(negedge clk);
        chk(tag, 32'(m_busy), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        int k;
        logic rdy;
        logic got9;

        reset = 1'b1;
        m_in_instr = '0;  m_in_valid = 1'b0;  m_flush = 1'b0;
        l_in_instr = '0;  l_in_valid = 1'b0;  l_flush = 1'b0;
        wr_in_instr = '0; wr_in_valid = 1'b0; wr_flush = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_instruct", 32'(m_instruct), 32'h0);
        chk("rst_pulse",    32'(m_pulse),    32'h0);
        chk("rst_count",    32'(m_count),    32'h0);
        chk("rst_issued",   32'(m_issued),   32'h0);
        chk("rst_ready",    32'(m_in_ready), 32'h1);
        chk("rst_busy",     32'(m_busy),     32'h0);

        // single load: one edge latency, held 2 cycles, then idle
        push_m(13'h0005);
        chk("t1_count_q",   32'(m_count),    32'd1);
        chk("t1_instr_pre", 32'(m_instruct), 32'h0);
        tick();
        chk("t1_instr",     32'(m_instruct), 32'h0005);
        chk("t1_pulse",     32'(m_pulse),    32'h1);
        chk("t1_count_pop", 32'(m_count),    32'd0);
        tick();
        chk("t1_pulse_lo",  32'(m_pulse),    32'h0);
        chk("t1_hold",      32'(m_instruct), 32'h0005);
        chk("t1_busy_hold", 32'(m_busy),     32'h1);
        tick();
        chk("t1_busy_end",  32'(m_busy),     32'h0);
        chk("t1_issued",    32'(m_issued),   32'd1);

        // load R0 then ALU: one stall cycle, pulse gap 3
        push_m(13'h0005);
        push_m(13'h1000);
        chk("t2_pulse_ld",  32'(m_pulse),    32'h1);
        chk("t2_instr_ld",  32'(m_instruct), 32'h0005);
        wait_pulse_m(n);
        chk("t2_gap",       32'(n),          32'd3);
        chk("t2_instr_alu", 32'(m_instruct), 32'h1000);
        chk("t2_issued",    32'(m_issued),   32'd3);
        wait_idle_m("t2_idle");

        // ALU then store R2: one stall
        push_m(13'h1800);
        push_m(13'h0C10);
        chk("t3_pulse_alu", 32'(m_pulse),    32'h1);
        chk("t3_instr_alu", 32'(m_instruct), 32'h1800);
        wait_pulse_m(n);
        chk("t3_gap_st23",  32'(n),          32'd3);
        chk("t3_instr_st",  32'(m_instruct), 32'h0C10);
        wait_idle_m("t3_idle_a");

        // ALU then store R0: no stall
        push_m(13'h1800);
        push_m(13'h0810);
        chk("t3_pulse_alu2", 32'(m_pulse),   32'h1);
        wait_pulse_m(n);
        chk("t3_gap_st01",  32'(n),          32'd2);
        chk("t3_instr_st0", 32'(m_instruct), 32'h0810);
        wait_idle_m("t3_idle_b");
        chk("t3_issued",    32'(m_issued),   32'd7);

        // flush during HOLD with 5 queued; same-cycle push dropped
        push_l(13'h0005);
        for (int i = 0; i < 5; i++)
            push_l(13'h0100 + 13'(i));
        chk("fl_count_pre", 32'(l_count),    32'd5);
        chk("fl_instr_pre", 32'(l_instruct), 32'h0005);
        l_flush    = 1'b1;
        l_in_instr = 13'h0AAA;
        l_in_valid = 1'b1;
        #1;
        chk("fl_ready_lo",  32'(l_in_ready), 32'h0);
        @(negedge clk);
        l_flush    = 1'b0;
        l_in_valid = 1'b0;
        chk("fl_count",     32'(l_count),    32'd0);
        chk("fl_busy",      32'(l_busy),     32'h0);
        chk("fl_instr",     32'(l_instruct), 32'h0005);
        tick();
        chk("fl_count_2",   32'(l_count),    32'd0);
        chk("fl_pulse",     32'(l_pulse),    32'h0);
        chk("fl_issued",    32'(l_issued),   32'd1);

        // fill: 8 accepted during a long hold, 9th waits for a pop
        push_l(13'h0007);
        acc = 0;
        l_in_instr = 13'h0100;
        l_in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rdy = l_in_ready;
            @(negedge clk);
            if (rdy) begin
                acc++;
                l_in_instr = 13'h0100 + 13'(acc);
            end
        end
        chk("fill_acc",     32'(acc),        32'd8);
        chk("fill_count",   32'(l_count),    32'd8);
        chk("fill_ready",   32'(l_in_ready), 32'h0);
        got9 = 1'b0;
        k = 0;
        for (int c = 1; c <= 100; c++) begin
            rdy = l_in_ready;
            @(negedge clk);
            if (rdy) begin
                got9 = 1'b1;
                k = c;
                break;
            end
        end
        l_in_valid = 1'b0;
        chk("fill_9th",     32'(got9),       32'h1);
        chk("fill_wait",    32'(k),          32'd58);
        chk("fill_count2",  32'(l_count),    32'd8);
        chk("fill_instr",   32'(l_instruct), 32'h0100);
        chk("fill_issued",  32'(l_issued),   32'd3);

        // async reset in the middle of a stall
        push_m(13'h0005);
        push_m(13'h1000);
        tick();
        tick();
        chk("rs_pulse_pre", 32'(m_pulse),    32'h0);
        chk("rs_busy_pre",  32'(m_busy),     32'h1);
        chk("rs_count_pre", 32'(m_count),    32'd1);
        reset = 1'b1;
        #1;
        chk("rs_instruct",  32'(m_instruct), 32'h0);
        chk("rs_pulse",     32'(m_pulse),    32'h0);
        chk("rs_count",     32'(m_count),    32'd0);
        chk("rs_issued",    32'(m_issued),   32'd0);
        chk("rs_busy",      32'(m_busy),     32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rs_no_issue",  32'(m_instruct), 32'h0);
        chk("rs_pulse_2",   32'(m_pulse),    32'h0);

        // issued_count wrap with back-to-back single-cycle issues
        wr_in_instr = 13'h0005;
        wr_in_valid = 1'b1;
        for (int c = 0; c < 70000 && wr_issued != 16'hFFFF; c++)
            @(negedge clk);
        chk("wrap_ffff",    32'(wr_issued),  32'h0000FFFF);
        tick();
        chk("wrap_zero",    32'(wr_issued),  32'h0);
        chk("wrap_pulse",   32'(wr_pulse),   32'h1);
        wr_in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
